// File: rtl/ro_puf_controller.sv
// RO-PUF measurement sequencer for one pair of ring oscillators.
// A challenge selects the stage configuration of both ROs. The controller
// enables the pair and lets it settle. It then counts rising edges of each
// RO over a fixed window. It reports both counts and which RO was faster.

// One RO channel: 3-flop synchroniser/edge detector plus a saturating counter.
module ro_puf_lane #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flip,
   input  logic             clr,
   input  logic             cnt_en,
   output logic [CNT_W-1:0] cnt_nxt
);
   logic [2:0]       sync_q;
   logic [CNT_W-1:0] cnt_q;
   logic             rise;

   // [0],[1] form the synchroniser; [2] holds the previous synced value
   assign rise = sync_q[1] & ~sync_q[2];

   // next count: clear on a new measurement, otherwise saturating increment
   always_comb begin
      cnt_nxt = cnt_q;
      if (clr)
         cnt_nxt = '0;
      else if (cnt_en && rise && (cnt_q != {CNT_W{1'b1}}))
         cnt_nxt = cnt_q + 1'b1;
   end

   // synchroniser shift and counter register
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
         cnt_q  <= '0;
      end else begin
         sync_q <= {sync_q[1:0], flip};
         cnt_q  <= cnt_nxt;
      end
   end
endmodule

module ro_puf_controller #(
   parameter int SETTLE_CYC = 16,
   parameter int WINDOW_CYC = 1024,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [5:0]       challenge,
   input  logic             ro_a_flip,
   input  logic             ro_b_flip,
   output logic             ro_enable,
   output logic [2:0]       ro_sel,
   output logic [2:0]       ro_bx,
   output logic             busy,
   output logic             done,
   output logic             response,
   output logic             tie,
   output logic [CNT_W-1:0] count_a,
   output logic [CNT_W-1:0] count_b
);
   localparam int NUM_LANES = 2;
   localparam int TMR_MAX   = (SETTLE_CYC > WINDOW_CYC) ? SETTLE_CYC : WINDOW_CYC;
   localparam int TMR_W     = $clog2(TMR_MAX + 1);

   typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_t;

   state_t                            state_q, state_d;
   logic [TMR_W-1:0]                  tmr_q;
   logic                              tmr_clr;
   logic                              load_chal;
   logic                              cnt_clr;
   logic                              cnt_en;
   logic                              capture;
   logic [NUM_LANES-1:0]              flip;
   logic [NUM_LANES-1:0][CNT_W-1:0]   cnt_nxt;

   assign flip = {ro_b_flip, ro_a_flip};

   // lane 0 = RO A, lane 1 = RO B
   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      ro_puf_lane #(.CNT_W(CNT_W)) u_lane (
         .clk     (clk),
         .reset   (reset),
         .flip    (flip[l]),
         .clr     (cnt_clr),
         .cnt_en  (cnt_en),
         .cnt_nxt (cnt_nxt[l])
      );
   end

   // state register
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // next state and per-state controls
   always_comb begin
      state_d   = state_q;
      tmr_clr   = 1'b1;
      load_chal = 1'b0;
      cnt_clr   = 1'b0;
      cnt_en    = 1'b0;
      capture   = 1'b0;
      ro_enable = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               load_chal = 1'b1;
               cnt_clr   = 1'b1;
               state_d   = SETTLE;
            end
         end
         SETTLE: begin
            ro_enable = 1'b1;
            tmr_clr   = 1'b0;
            if (tmr_q == TMR_W'(SETTLE_CYC - 1)) begin
               tmr_clr = 1'b1;
               state_d = MEASURE;
            end
         end
         MEASURE: begin
            ro_enable = 1'b1;
            cnt_en    = 1'b1;
            tmr_clr   = 1'b0;
            if (tmr_q == TMR_W'(WINDOW_CYC - 1)) begin
               tmr_clr = 1'b1;
               capture = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // cycle counter within SETTLE/MEASURE
   always_ff @(posedge clk) begin
      if (reset || tmr_clr) tmr_q <= '0;
      else                  tmr_q <= tmr_q + 1'b1;
   end

   // challenge latch, held until the next accepted start
   always_ff @(posedge clk) begin
      if (reset) begin
         ro_sel <= '0;
         ro_bx  <= '0;
      end else if (load_chal) begin
         ro_sel <= challenge[5:3];
         ro_bx  <= challenge[2:0];
      end
   end

   // results: capture the final count (including this cycle's edge) into DONE
   always_ff @(posedge clk) begin
      if (reset) begin
         count_a  <= '0;
         count_b  <= '0;
         response <= 1'b0;
         tie      <= 1'b0;
      end else if (capture) begin
         count_a  <= cnt_nxt[0];
         count_b  <= cnt_nxt[1];
         response <= cnt_nxt[0] > cnt_nxt[1];
         tie      <= cnt_nxt[0] == cnt_nxt[1];
      end
   end
endmodule
